leaf_rx_demux: RTL and testbench
================================

LEAF_RX_DEMUX -- requirements
Module: leaf_rx_demux

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of operator input streams (1..14).
REQ-002 Parameter FIFO_DEPTH, default 8, entries per port FIFO (power of two, >=2).
REQ-003 Parameter LEAF_ADDR, default 0, 5-bit address of this leaf.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 din_leaf_bft2interface  in  49  BFT packet: [48] valid, [47:43] dst leaf, [42:39] dst port, [38:32] tag (ignored), [31:0] payload.
REQ-007 dout_data  out  32*NUM_PORTS  per-port payload; port p in bits [32p+31:32p].
REQ-008 dout_valid  out  NUM_PORTS  per-port valid.
REQ-009 dout_ready  in  NUM_PORTS  per-port ready from operator.
REQ-010 resend  out  1  one-cycle pulse requesting BFT retransmit of a dropped packet; drives the page's resend input.
REQ-011 resend_port  out  4  dst port of the packet that caused resend; valid while resend=1.
REQ-012 ap_start  out  1  operator start, driven to the page's ap_start input.
REQ-013 misroute_cnt  out  16  saturating count of packets with wrong dst leaf.

Function
REQ-014 Input sampled every cycle; no backpressure to BFT; packet accepted when bit 48 = 1.
REQ-015 Input registered once; FIFO write occurs in cycle after sampling (input-to-dout_valid latency 2 cycles when FIFO empty).
REQ-016 Packet with dst leaf != LEAF_ADDR: dropped, misroute_cnt +1, saturating at 0xFFFF; no resend.
REQ-017 Packet with dst port < NUM_PORTS and that FIFO not full: payload written to that FIFO.
REQ-018 Packet with dst port < NUM_PORTS and FIFO full (after accounting for a same-cycle pop): dropped; resend=1, resend_port=dst port for exactly one cycle.
REQ-019 Simultaneous pop and push on a full FIFO: push succeeds, no resend.
REQ-020 Dst port 15 is control: payload bit0=1 sets ap_start, bit0=0 clears ap_start; no FIFO write.
REQ-021 Dst port in [NUM_PORTS,14]: dropped silently, no counters, no resend.
REQ-022 FIFO pop on dout_valid & dout_ready; dout_data is FIFO head, stable while valid & !ready.
REQ-023 dout_valid = FIFO non-empty; FIFO pointers wrap modulo FIFO_DEPTH with extra bit for full/empty.
REQ-024 Ports independent: stall on one port never blocks delivery or acceptance on another.
REQ-025 Control state machine: IDLE (ap_start=0) -> RUN on start packet; RUN -> IDLE on stop packet; repeated start in RUN / stop in IDLE: no change.
REQ-026 FIFO acceptance independent of ap_start (data may arrive before start).

Reset
REQ-027 reset=0 at clock edge: all FIFOs emptied, input register cleared, dout_valid=0, resend=0, resend_port=0, ap_start=0, state IDLE, misroute_cnt=0.
REQ-028 dout_data undefined-but-stable after reset; verified only when dout_valid=1.
REQ-029 Reset mid-stream: packets in FIFOs discarded, packet sampled in reset cycle discarded, no resend issued.

Structure
REQ-030 Shared package holds packet field positions/widths, CTRL_PORT=15, payload width 32, packet width 49.
REQ-031 One sub-module leaf_rx_fifo (single-clock, synchronous active-low reset, depth FIFO_DEPTH, full/empty/pop/push) instantiated NUM_PORTS times.

Verification
REQ-032 Packet leaf 0 port 1 payload 0xDEADBEEF, ready=1 -> dout_valid[1] 2 cycles later, dout_data[63:32]=0xDEADBEEF, one cycle.
REQ-033 dout_ready[0]=0, send 9 packets to port 0 -> 8 buffered in order, 9th gives resend=1 resend_port=0; port 1 traffic unaffected.
REQ-034 FIFO 0 full, ready=1 in same cycle as new port-0 packet -> no resend, order preserved.
REQ-035 Control packet port 15 payload 1 -> ap_start=1 next+1 cycle; payload 0 -> ap_start=0; no dout_valid change.
REQ-036 70000 packets with leaf 3 -> misroute_cnt saturates at 0xFFFF, no FIFO writes, no resend.
REQ-037 Fill FIFO 1 with 4 entries, ap_start=1, assert reset=0 one cycle -> dout_valid=0, ap_start=0, misroute_cnt=0.

Source files
------------

// File: rtl/leaf_rx_demux_pkg.sv
// ---------------------------------------------------------------------------
// leaf_rx_demux_pkg
// Purpose : shared definitions for the BFT leaf receive demultiplexer:
//           packet field positions/widths, control port number, payload
//           width, control FSM state type and the decoded packet struct.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package leaf_rx_demux_pkg;

  // Raw BFT packet layout: [48] valid, [47:43] leaf, [42:39] port,
  // [38:32] tag, [31:0] payload.
  localparam int PKT_W       = 49;
  localparam int PAYLOAD_W   = 32;
  localparam int LEAF_W      = 5;
  localparam int PORT_W      = 4;
  localparam int TAG_W       = 7;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_LSB    = 43;
  localparam int PORT_LSB    = 39;
  localparam int TAG_LSB     = 32;
  localparam int PAYLOAD_LSB = 0;

  // Destination port reserved for start/stop control of the operator.
  localparam logic [PORT_W-1:0] CTRL_PORT = 4'd15;

  localparam int          CNT_W        = 16;
  localparam logic [15:0] MISROUTE_MAX = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Packet with the ignored tag field stripped off.
  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [PAYLOAD_W-1:0] payload;
  } rx_pkt_t;

endpackage

// File: rtl/leaf_rx_fifo.sv
// ---------------------------------------------------------------------------
// leaf_rx_fifo
// Purpose : single-clock FIFO holding payloads for one operator port.
//           Head word is presented combinationally so the consumer sees the
//           payload in the same cycle the FIFO becomes non-empty.
// Ports   : clk      - clock, rising edge
//           i_rst_n  - synchronous active-low reset (empties the FIFO)
//           i_push   - write i_wdata this cycle
//           i_wdata  - write data
//           i_pop    - discard the head word this cycle
//           o_rdata  - head word (meaningful only while !o_empty)
//           o_full   - DEPTH entries stored
//           o_empty  - no entries stored
// ---------------------------------------------------------------------------
module leaf_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the
  // address bits are equal.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves in the same
  // cycle: the write lands in the slot being vacated.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/leaf_rx_demux.sv
// ---------------------------------------------------------------------------
// leaf_rx_demux
// Purpose : receive side of a BFT leaf. Registers each incoming packet,
//           then routes its payload into one per-port FIFO, handles the
//           start/stop control port, counts misrouted packets and requests
//           retransmission of packets dropped on a full FIFO.
// Ports   : clk                    - clock, rising edge
//           reset                  - synchronous active-low reset
//           din_leaf_bft2interface - 49-bit BFT packet (no backpressure)
//           dout_data              - per-port payload, port p at [32p+31:32p]
//           dout_valid             - per-port FIFO non-empty
//           dout_ready             - per-port consumer ready
//           resend                 - one-cycle retransmit request
//           resend_port            - port of the dropped packet
//           ap_start               - operator start level
//           misroute_cnt           - saturating wrong-leaf packet count
// ---------------------------------------------------------------------------
module leaf_rx_demux
  import leaf_rx_demux_pkg::*;
#(
  parameter int                NUM_PORTS  = 2,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [LEAF_W-1:0] LEAF_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PKT_W-1:0]               din_leaf_bft2interface,
  output logic [PAYLOAD_W*NUM_PORTS-1:0] dout_data,
  output logic [NUM_PORTS-1:0]           dout_valid,
  input  logic [NUM_PORTS-1:0]           dout_ready,
  output logic                           resend,
  output logic [PORT_W-1:0]              resend_port,
  output logic                           ap_start,
  output logic [CNT_W-1:0]               misroute_cnt
);

  rx_pkt_t           w_pkt_in;
  rx_pkt_t           r_pkt;
  logic              w_unused_tag;

  logic              w_leaf_hit;
  logic              w_misroute;
  logic              w_ctrl;

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_drop;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;

  logic              r_resend;
  logic [PORT_W-1:0] r_resend_port;
  logic [CNT_W-1:0]  r_misroute_cnt;

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_next;
  logic              w_ap_start;

  // -------------------------------------------------------------------------
  // Input register (tag is carried by the BFT but has no meaning here)
  // -------------------------------------------------------------------------
  assign w_pkt_in = {din_leaf_bft2interface[VALID_BIT],
                     din_leaf_bft2interface[LEAF_LSB +: LEAF_W],
                     din_leaf_bft2interface[PORT_LSB +: PORT_W],
                     din_leaf_bft2interface[PAYLOAD_LSB +: PAYLOAD_W]};
  assign w_unused_tag = ^din_leaf_bft2interface[TAG_LSB +: TAG_W];

  // A packet present in the reset cycle is discarded by clearing here.
  always_ff @(posedge clk) begin
    if (!reset) r_pkt <= '0;
    else        r_pkt <= w_pkt_in;
  end

  // -------------------------------------------------------------------------
  // Packet classification
  // -------------------------------------------------------------------------
  assign w_leaf_hit = r_pkt.valid && (r_pkt.leaf == LEAF_ADDR);
  assign w_misroute = r_pkt.valid && (r_pkt.leaf != LEAF_ADDR);
  assign w_ctrl     = w_leaf_hit && (r_pkt.port == CTRL_PORT);

  // -------------------------------------------------------------------------
  // Per-port FIFOs. Ports in [NUM_PORTS,14] match no lane and fall through
  // with no side effects. The full check credits a same-cycle pop so a
  // draining port never drops.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic w_sel;

    assign w_sel      = w_leaf_hit && (r_pkt.port == PORT_W'(gi));
    assign w_pop[gi]  = ~w_empty[gi] & dout_ready[gi];
    assign w_push[gi] = w_sel & (~w_full[gi] | w_pop[gi]);
    assign w_drop[gi] = w_sel & w_full[gi] & ~w_pop[gi];

    leaf_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_W)
    ) u_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_push  (w_push[gi]),
      .i_wdata (r_pkt.payload),
      .i_pop   (w_pop[gi]),
      .o_rdata (dout_data[gi*PAYLOAD_W +: PAYLOAD_W]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );
  end

  assign dout_valid = ~w_empty;

  // -------------------------------------------------------------------------
  // Resend request: registered so it lines up with the cycle in which the
  // payload would otherwise have become visible.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resend      <= 1'b0;
      r_resend_port <= '0;
    end else begin
      r_resend      <= |w_drop;
      r_resend_port <= (|w_drop) ? r_pkt.port : '0;
    end
  end

  assign resend      = r_resend;
  assign resend_port = r_resend_port;

  // -------------------------------------------------------------------------
  // Misroute counter, sticks at all-ones
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_misroute_cnt <= '0;
    end else if (w_misroute && (r_misroute_cnt != MISROUTE_MAX)) begin
      r_misroute_cnt <= r_misroute_cnt + 1'b1;
    end
  end

  assign misroute_cnt = r_misroute_cnt;

  // -------------------------------------------------------------------------
  // Start/stop control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ap_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ctrl && r_pkt.payload[0]) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_ap_start = 1'b1;
        if (w_ctrl && !r_pkt.payload[0]) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign ap_start = w_ap_start;

endmodule

// File: tb/tb_leaf_rx_demux.sv
// ---------------------------------------------------------------------------
// tb_leaf_rx_demux
// Purpose : self-checking bench for leaf_rx_demux (NUM_PORTS=2, depth 8,
//           leaf 0). Delivered payloads and resend pulses are checked
//           against scoreboard queues filled when stimulus is driven.
// ---------------------------------------------------------------------------
module tb_leaf_rx_demux;

  localparam int NP = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [48:0]       din;
  logic [32*NP-1:0]  dout_data;
  logic [NP-1:0]     dout_valid;
  logic [NP-1:0]     dout_ready;
  logic              resend;
  logic [3:0]        resend_port;
  logic              ap_start;
  logic [15:0]       misroute_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q [NP][$];
  logic [3:0]  exp_resend_q[$];

  always #5 clk = ~clk;

  leaf_rx_demux #(
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (8),
    .LEAF_ADDR  (5'd0)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .din_leaf_bft2interface (din),
    .dout_data              (dout_data),
    .dout_valid             (dout_valid),
    .dout_ready             (dout_ready),
    .resend                 (resend),
    .resend_port            (resend_port),
    .ap_start               (ap_start),
    .misroute_cnt           (misroute_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [4:0] leaf, input logic [3:0] port, input logic [31:0] pay);
    din = {1'b1, leaf, port, 7'h2A, pay};
    @(posedge clk);
    #1;
    din = '0;
    $display("tx leaf=%0d port=%0d payload=%h", leaf, port, pay);
  endtask

  // Scoreboard: delivered payloads
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (dout_valid[p] === 1'b1 && dout_ready[p] === 1'b1) begin
          if (exp_q[p].size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_rx port%0d: got %h expected none", p, dout_data[32*p +: 32]);
          end else begin
            logic [31:0] e;
            e = exp_q[p].pop_front();
            check($sformatf("rx_port%0d", p), 64'(dout_data[32*p +: 32]), 64'(e));
            $display("rx port%0d data=%h", p, dout_data[32*p +: 32]);
          end
        end
      end
    end
  end

  // Scoreboard: resend pulses
  always @(negedge clk) begin
    if (reset === 1'b1 && resend === 1'b1) begin
      if (exp_resend_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_resend: got port %0d expected none", resend_port);
      end else begin
        logic [3:0] e;
        e = exp_resend_q.pop_front();
        check("resend_port", 64'(resend_port), 64'(e));
        $display("resend port=%0d", resend_port);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  leaf;
    logic [3:0]  port;
    logic [31:0] pay;
    bit          deliver;
    logic        exp_ap;
    logic [15:0] exp_mis;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{5'd0,  4'd0,  32'h1111_1111, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{5'd0,  4'd1,  32'h2222_2222, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{5'd3,  4'd0,  32'h0000_0033, 1'b0, 1'b0, 16'd1};
    tbl[3]  = '{5'd0,  4'd5,  32'h0000_0044, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{5'd0,  4'd14, 32'h0000_0055, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{5'd0,  4'd15, 32'h0000_0001, 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{5'd0,  4'd15, 32'h0000_0001, 1'b0, 1'b1, 16'd1};
    tbl[7]  = '{5'd31, 4'd15, 32'h0000_0000, 1'b0, 1'b1, 16'd2};
    tbl[8]  = '{5'd0,  4'd15, 32'hFFFF_FFFE, 1'b0, 1'b0, 16'd2};
    tbl[9]  = '{5'd0,  4'd15, 32'h0000_0000, 1'b0, 1'b0, 16'd2};
    tbl[10] = '{5'd0,  4'd0,  32'hA5A5_A5A5, 1'b1, 1'b0, 16'd2};
    tbl[11] = '{5'd1,  4'd1,  32'h0000_0005, 1'b0, 1'b0, 16'd3};

    reset      = 1'b0;
    din        = '0;
    dout_ready = '1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_valid",    64'(dout_valid),   64'd0);
    check("rst_resend",   64'(resend),       64'd0);
    check("rst_rport",    64'(resend_port),  64'd0);
    check("rst_ap_start", 64'(ap_start),     64'd0);
    check("rst_misroute", 64'(misroute_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Table-driven classification vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].deliver) exp_q[tbl[i].port].push_back(tbl[i].pay);
      send(tbl[i].leaf, tbl[i].port, tbl[i].pay);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_ap_start", i), 64'(ap_start),     64'(tbl[i].exp_ap));
      check($sformatf("vec%0d_misroute", i), 64'(misroute_cnt), 64'(tbl[i].exp_mis));
      @(posedge clk);
      #1;
    end

    // Two-cycle latency, one-cycle valid with ready high
    exp_q[1].push_back(32'hDEAD_BEEF);
    send(5'd0, 4'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(dout_valid[1]), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(dout_valid[1]), 64'd1);
    check("lat_cycle2_data",  64'(dout_data[63:32]), 64'hDEAD_BEEF);
    @(negedge clk);
    check("lat_cycle3_valid", 64'(dout_valid[1]), 64'd0);
    @(posedge clk);
    #1;

    // Port 0 stalled: 8 buffered, 9th dropped with resend; port 1 flows
    dout_ready = 2'b10;
    for (int i = 0; i < 8; i++) begin
      exp_q[0].push_back(32'h100 + 32'(i));
      send(5'd0, 4'd0, 32'h100 + 32'(i));
    end
    exp_resend_q.push_back(4'd0);
    send(5'd0, 4'd0, 32'h108);
    exp_q[1].push_back(32'h300);
    send(5'd0, 4'd1, 32'h300);
    exp_q[1].push_back(32'h301);
    send(5'd0, 4'd1, 32'h301);
    repeat (3) @(negedge clk);
    check("full_resend_seen", 64'(exp_resend_q.size()), 64'd0);
    check("port1_drained",    64'(exp_q[1].size()),     64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_valid%0d", k), 64'(dout_valid[0]),  64'd1);
      check($sformatf("stall_data%0d", k),  64'(dout_data[31:0]), 64'h100);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Full FIFO with pop in the same cycle as the push: accepted in order
    exp_q[0].push_back(32'h200);
    send(5'd0, 4'd0, 32'h200);
    dout_ready = 2'b11;
    repeat (14) @(negedge clk);
    check("pop_push_drained", 64'(exp_q[0].size()), 64'd0);
    @(posedge clk);
    #1;

    // Misroute saturation
    din = {1'b1, 5'd3, 4'd0, 7'h00, 32'hCAFE_0000};
    repeat (70000) @(posedge clk);
    #1 din = '0;
    $display("tx 70000 packets leaf=3");
    repeat (3) @(negedge clk);
    check("misroute_sat", 64'(misroute_cnt), 64'hFFFF);
    check("misroute_no_valid", 64'(dout_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-stream
    dout_ready = 2'b01;
    for (int i = 0; i < 4; i++) send(5'd0, 4'd1, 32'h400 + 32'(i));
    send(5'd0, 4'd15, 32'h1);
    repeat (3) @(negedge clk);
    check("pre_rst_valid1", 64'(dout_valid[1]), 64'd1);
    check("pre_rst_ap",     64'(ap_start),      64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    din   = {1'b1, 5'd0, 4'd0, 7'h00, 32'h500};
    @(posedge clk);
    #1;
    reset      = 1'b1;
    din        = '0;
    dout_ready = '1;
    $display("tx reset pulse");
    @(negedge clk);
    check("mid_rst_valid",    64'(dout_valid),   64'd0);
    check("mid_rst_ap",       64'(ap_start),     64'd0);
    check("mid_rst_misroute", 64'(misroute_cnt), 64'd0);
    check("mid_rst_resend",   64'(resend),       64'd0);
    repeat (3) @(negedge clk);
    check("post_rst_valid",   64'(dout_valid),   64'd0);

    check("end_q0_empty",     64'(exp_q[0].size()),     64'd0);
    check("end_q1_empty",     64'(exp_q[1].size()),     64'd0);
    check("end_resend_empty", 64'(exp_resend_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
